// File: rtl/bird_physics_ctrl.sv
// bird_physics_ctrl
//  Per-frame game sequencer for the sprite box. Holds the box top row and vertical
//  velocity, runs the IDLE/PLAY/DEAD game state, and applies gravity/flap physics once
//  per frame on the start-of-frame pixel (h_count==1, v_count==1).
//  Build macro JUMP_DEBOUNCE_EN: when defined, the synchronized jump button is debounced
//  (must hold a new level for DEBOUNCE_CYC cycles) before edge detection.
`timescale 1ns/1ps
module bird_physics_ctrl #(
  parameter logic        [9:0]  DEFAULT_Y    = 10'd200,
  parameter logic        [9:0]  BOX_H        = 10'd72,
  parameter logic        [9:0]  PORCH_TOP    = 10'd36,
  parameter logic        [9:0]  PORCH_BOT    = 10'd500,
  parameter logic signed [7:0]  GRAVITY      = 8'sd1,
  parameter logic signed [7:0]  JUMP_V       = 8'sd10,
  parameter logic signed [7:0]  VMAX         = 8'sd15,
  parameter logic        [7:0]  DEAD_FRAMES  = 8'd60,
  parameter logic        [19:0] DEBOUNCE_CYC = 20'd250000
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        jump,
  input  logic        hit,
  output logic [9:0]  box_y,
  output logic [7:0]  velocity,
  output logic [1:0]  state,
  output logic        frame_tick,
  output logic [15:0] frames_alive
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DEAD = 2'b10
  } game_state_t;

  game_state_t state_q;

  logic jump_meta;
  logic jump_sync;
  logic jump_level;
  logic jump_prev;
  logic jump_evt;
  logic pending;
  logic [7:0] dead_cnt;

  logic signed [8:0]  vel_grav;
  logic signed [8:0]  vel_fall;
  logic signed [8:0]  vel_next;
  logic signed [10:0] y_next;
  logic signed [11:0] y_bottom;
  logic               hit_ceiling;
  logic               hit_floor;

  assign state = state_q;

  // Two-flop synchronizer bringing the raw pushbutton into the clk_25 domain.
  always_ff @(posedge clk_25) begin
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      jump_meta <= 1'b0;
      jump_sync <= 1'b0;
    end else begin
      jump_meta <= jump;
      jump_sync <= jump_meta;
    end
  end

`ifdef JUMP_DEBOUNCE_EN
  logic [19:0] deb_cnt;

  // Debounced level follows the synchronized button only after DEBOUNCE_CYC stable cycles.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      deb_cnt    <= 20'd0;
      jump_level <= 1'b0;
    end else if (jump_sync == jump_level) begin
      deb_cnt <= 20'd0;
    end else if (deb_cnt == DEBOUNCE_CYC - 20'd1) begin
      jump_level <= jump_sync;
      deb_cnt    <= 20'd0;
    end else begin
      deb_cnt <= deb_cnt + 20'd1;
    end
  end
`else
  assign jump_level = jump_sync;
`endif

  // Rising-edge detector: jump_evt is a single-cycle press event.
  always_ff @(posedge clk_25) begin
    if (rst) jump_prev <= 1'b0;
    else     jump_prev <= jump_level;
  end

  assign jump_evt = jump_level & ~jump_prev;

  // Registered start-of-frame strobe; physics updates on the edge where it is high.
  always_ff @(posedge clk_25) begin
    if (rst) frame_tick <= 1'b0;
    else     frame_tick <= (h_count == 10'd1) && (v_count == 10'd1);
  end

  // Next-frame velocity and position, widened so clamping and the floor test cannot wrap.
  always_comb begin
    // NOTE: every always_comb output is fully assigned on all paths, so no latch can be inferred.
    vel_grav = $signed({velocity[7], velocity}) + $signed({GRAVITY[7], GRAVITY});
    if (vel_grav > $signed({VMAX[7], VMAX})) vel_fall = $signed({VMAX[7], VMAX});
    else                                     vel_fall = vel_grav;
    // A flap pending (or arriving on the tick itself) overrides gravity for this frame.
    if (pending || jump_evt) vel_next = -$signed({JUMP_V[7], JUMP_V});
    else                     vel_next = vel_fall;
    y_next      = $signed({1'b0, box_y}) + $signed({{2{vel_next[8]}}, vel_next});
    y_bottom    = $signed({y_next[10], y_next}) + $signed({2'b00, BOX_H});
    hit_ceiling = y_next < $signed({1'b0, PORCH_TOP});
    hit_floor   = y_bottom >= $signed({2'b00, PORCH_BOT});
  end

  // Game state machine with all box/velocity/score registers updated in one place.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q      <= IDLE;
      box_y        <= DEFAULT_Y;
      velocity     <= 8'd0;
      frames_alive <= 16'd0;
      pending      <= 1'b0;
      dead_cnt     <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          box_y    <= DEFAULT_Y;
          velocity <= 8'd0;
          pending  <= 1'b0;
          if (jump_evt) begin
            state_q      <= PLAY;
            velocity     <= -JUMP_V;
            frames_alive <= 16'd0;
          end
        end

        PLAY: begin
          if (hit) begin
            // Collision freezes the box; it beats a coincident frame update.
            state_q  <= DEAD;
            dead_cnt <= 8'd0;
            pending  <= 1'b0;
          end else if (frame_tick) begin
            pending <= 1'b0;
            if (hit_ceiling) begin
              box_y    <= PORCH_TOP;
              velocity <= 8'd0;
              if (frames_alive != 16'hFFFF) frames_alive <= frames_alive + 16'd1;
            end else if (hit_floor) begin
              box_y    <= PORCH_BOT - BOX_H;
              velocity <= 8'd0;
              state_q  <= DEAD;
              dead_cnt <= 8'd0;
            end else begin
              box_y    <= y_next[9:0];
              velocity <= vel_next[7:0];
              if (frames_alive != 16'hFFFF) frames_alive <= frames_alive + 16'd1;
            end
          end else if (jump_evt) begin
            pending <= 1'b1;
          end
        end

        DEAD: begin
          pending <= 1'b0;
          if (jump_evt && (dead_cnt == DEAD_FRAMES)) begin
            state_q  <= IDLE;
            box_y    <= DEFAULT_Y;
            velocity <= 8'd0;
          end else if (frame_tick && (dead_cnt != DEAD_FRAMES)) begin
            dead_cnt <= dead_cnt + 8'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule
